// File: rtl/output_port_pkg.sv
// Shared constants and width derivations for the output port buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package output_port_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Read/write pointer width; DEPTH is a power of two >= 2, so pointers
    // wrap modulo DEPTH on plain binary overflow.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must represent 0..DEPTH inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/output_port_buffer_out_fifo.sv
// out_fifo: circular-buffer FIFO with registered occupancy, used behind the output stage.
// Latency: a push is visible at pop_dat one edge later; pop_dat is the combinational head.
// Backpressure: pushes while full and pops while empty are ignored; clr empties on the next edge.
// Ports: clk/rst_n (async active-low), clr (sync), push/push_dat, pop/pop_dat, full, empty, level.
module out_fifo
    import output_port_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PW   = ptr_width(DEPTH),
    localparam int LW   = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == LW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // Guard internally so a caller mistake can never corrupt the pointers.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + LW'(1);
                2'b01:   cnt_d = cnt_q - LW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only observable once counted valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/output_port_buffer.sv
// output_port_buffer: DEPTH-entry FIFO feeding a registered valid/ready output stage; DEPTH+1 words total.
// Latency: 2 edges from a write into an empty buffer to out_valid (FIFO write, then output load).
// Backpressure: out_ready low holds data_out/out_valid; writes while full are dropped and set sticky overflow.
// Ports: reg_clk, reg_rst_n (async active-low), reg_clr (sync clear), reg_en/data_in (write),
//        data_out/out_valid/out_ready (consumer), full, overflow, and level when
//        OUTPUT_PORT_BUFFER_LEVEL_EN is defined (FIFO occupancy, output stage excluded).
module output_port_buffer
    import output_port_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int LW   = level_width(DEPTH)
) (
    input  logic             reg_clk,
    input  logic             reg_rst_n,
    input  logic             reg_clr,
    input  logic             reg_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
`ifdef OUTPUT_PORT_BUFFER_LEVEL_EN
    output logic [LW-1:0]    level,
`endif
    output logic             overflow
);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LW-1:0]    fifo_level;

    // full is the registered occupancy flag: a pop on the same edge does
    // not make room for a write.
    assign fifo_push = reg_en && !fifo_full;

    // Load the output stage whenever it is empty or being drained this edge.
    assign fifo_pop  = !fifo_empty && (!out_valid_q || out_ready);

    out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (reg_clk),
        .rst_n    (reg_rst_n),
        .clr      (reg_clr),
        .push     (fifo_push),
        .push_dat (data_in),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_comb begin
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        if (reg_clr) begin
            // data_out intentionally keeps its last word across a clear.
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (fifo_pop) begin
                data_out_d  = fifo_head;
                out_valid_d = 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (reg_en && fifo_full) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge reg_clk or negedge reg_rst_n) begin
        if (!reg_rst_n) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign full      = fifo_full;

`ifdef OUTPUT_PORT_BUFFER_LEVEL_EN
    assign level = fifo_level;
`else
    logic unused_level;
    assign unused_level = ^fifo_level;
`endif

endmodule

// File: tb/tb_output_port_buffer.sv
// Testbench for output_port_buffer (WIDTH=8, DEPTH=4).
// Latency: n/a.
// Backpressure: driven directly from the stimulus via out_ready.
module tb_output_port_buffer;

    logic       reg_clk = 1'b0;
    logic       reg_rst_n;
    logic       reg_clr;
    logic       reg_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       full;
    logic       overflow;
`ifdef OUTPUT_PORT_BUFFER_LEVEL_EN
    logic [2:0] level;
`endif

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb [$];

    output_port_buffer #(.WIDTH(8), .DEPTH(4)) dut (
        .reg_clk   (reg_clk),
        .reg_rst_n (reg_rst_n),
        .reg_clr   (reg_clr),
        .reg_en    (reg_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
`ifdef OUTPUT_PORT_BUFFER_LEVEL_EN
        .level     (level),
`endif
        .overflow  (overflow)
    );

    always #5 reg_clk = ~reg_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge reg_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        reg_en  = 1'b1;
        data_in = d;
        tick();
        reg_en  = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!out_valid) break;
            tick();
        end
        chk("drain_done", 64'(out_valid), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid and
    // ready are both high mid-cycle; compare against the scoreboard head.
    always @(negedge reg_clk) begin
        logic [7:0] exp_w;
        if (reg_rst_n && !reg_clr && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got 0x%0h expected no word", data_out);
            end else begin
                exp_w = sb.pop_front();
                if (data_out !== exp_w) begin
                    bad++;
                    $display("FAIL sb_word: got 0x%0h expected 0x%0h", data_out, exp_w);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reg_rst_n = 1'b0;
        reg_clr   = 1'b0;
        reg_en    = 1'b0;
        data_in   = 8'h00;
        out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_data_out", 64'(data_out), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_overflow", 64'(overflow), 64'h0);
`ifdef OUTPUT_PORT_BUFFER_LEVEL_EN
        chk("rst_level", 64'(level), 64'h0);
`endif
        tick();
        tick();
        reg_rst_n = 1'b1;

        // Two-edge latency, then drain leaves data_out holding its word
        out_ready = 1'b1;
        sb.push_back(8'hA5);
        wr(8'hA5);
        chk("lat_edge_n_valid", 64'(out_valid), 64'h0);
        tick();
        chk("lat_edge_n1_valid", 64'(out_valid), 64'h1);
        chk("lat_edge_n1_data", 64'(data_out), 64'hA5);
        tick();
        chk("lat_after_take_valid", 64'(out_valid), 64'h0);
        chk("lat_after_take_data", 64'(data_out), 64'hA5);

        // Fill DEPTH+1 words, drop the sixth
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) sb.push_back(8'(i));
            wr(8'(i));
            if (i == 5) begin
                chk("fill_full", 64'(full), 64'h1);
                chk("fill_out_valid", 64'(out_valid), 64'h1);
                chk("fill_data_out", 64'(data_out), 64'h01);
                chk("fill_no_overflow_yet", 64'(overflow), 64'h0);
            end
        end
        chk("drop_overflow", 64'(overflow), 64'h1);
        chk("drop_full", 64'(full), 64'h1);
        chk("drop_data_out", 64'(data_out), 64'h01);
`ifdef OUTPUT_PORT_BUFFER_LEVEL_EN
        chk("drop_level", 64'(level), 64'h4);
`endif
        out_ready = 1'b1;
        drain(20);
        chk("overflow_sticky", 64'(overflow), 64'h1);

        // Simultaneous write and pop with 2 entries in the FIFO
        out_ready = 1'b0;
        sb.push_back(8'h10);
        sb.push_back(8'h11);
        sb.push_back(8'h12);
        wr(8'h10);
        wr(8'h11);
        wr(8'h12);
`ifdef OUTPUT_PORT_BUFFER_LEVEL_EN
        chk("occ2_level_before", 64'(level), 64'h2);
`endif
        out_ready = 1'b1;
        sb.push_back(8'h13);
        wr(8'h13);
        chk("occ2_data_out", 64'(data_out), 64'h11);
        chk("occ2_full", 64'(full), 64'h0);
`ifdef OUTPUT_PORT_BUFFER_LEVEL_EN
        chk("occ2_level_after", 64'(level), 64'h2);
`endif
        out_ready = 1'b0;
        sb.push_back(8'h14);
        wr(8'h14);
        chk("occ3_not_full", 64'(full), 64'h0);
        sb.push_back(8'h15);
        wr(8'h15);
        chk("occ4_full", 64'(full), 64'h1);
        out_ready = 1'b1;
        drain(20);

        // Stall stability
        out_ready = 1'b0;
        sb.push_back(8'h3C);
        wr(8'h3C);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("stall_data", 64'(data_out), 64'h3C);
            chk("stall_valid", 64'(out_valid), 64'h1);
            tick();
        end

        // Soft clear with 3 FIFO entries and overflow still set
        wr(8'h21);
        wr(8'h22);
        wr(8'h23);
        chk("clr_pre_overflow", 64'(overflow), 64'h1);
        reg_clr = 1'b1;
        tick();
        reg_clr = 1'b0;
        chk("clr_out_valid", 64'(out_valid), 64'h0);
        chk("clr_full", 64'(full), 64'h0);
        chk("clr_overflow", 64'(overflow), 64'h0);
        chk("clr_data_hold", 64'(data_out), 64'h3C);
`ifdef OUTPUT_PORT_BUFFER_LEVEL_EN
        chk("clr_level", 64'(level), 64'h0);
`endif
        sb.delete();
        out_ready = 1'b1;
        sb.push_back(8'h44);
        wr(8'h44);
        tick();
        chk("post_clr_valid", 64'(out_valid), 64'h1);
        chk("post_clr_data", 64'(data_out), 64'h44);
        drain(10);

        // Asynchronous reset while full
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'(8'h50 + i));
        chk("prerst_full", 64'(full), 64'h1);
        @(posedge reg_clk);
        #3;
        reg_rst_n = 1'b0;
        #1;
        chk("arst_data_out", 64'(data_out), 64'h0);
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_full", 64'(full), 64'h0);
        chk("arst_overflow", 64'(overflow), 64'h0);
        #2;
        reg_rst_n = 1'b1;
        out_ready = 1'b1;
        sb.push_back(8'h77);
        wr(8'h77);
        chk("postrst_edge_n_valid", 64'(out_valid), 64'h0);
        tick();
        chk("postrst_valid", 64'(out_valid), 64'h1);
        chk("postrst_data", 64'(data_out), 64'h77);
        tick();
        chk("postrst_taken", 64'(out_valid), 64'h0);
        chk("postrst_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
